// File: rtl/sched_loader.sv
// Schedule loader: streams a host schedule into the schedule controller,
// then arms, starts and stops it while marking iteration boundaries.
module sched_loader #(
  parameter int CTRL_WIDTH  = 24,
  parameter int ITER_PERIOD = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_go,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [CTRL_WIDTH-1:0] host_word,
  input  logic                  host_last,
  input  logic                  run_req,
  input  logic                  halt_req,
  output logic                  load_ctrl,
  output logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic                  start_ctrl,
  output logic                  stop_ctrl,
  output logic                  armed,
  output logic                  running,
  output logic                  iter_tick,
  output logic                  err
);

  localparam int CNT_W = $clog2(ITER_PERIOD + 1);
  localparam int CYC_W = (ITER_PERIOD > 1) ? $clog2(ITER_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ITER_PERIOD - 1);
  localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(ITER_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
  logic [CYC_W-1:0]      cyc_cnt_reg, cyc_cnt_next;
  logic [CTRL_WIDTH-1:0] ctrl_in_reg, ctrl_in_next;
  logic                  load_ctrl_reg, load_ctrl_next;
  logic                  start_ctrl_reg, start_ctrl_next;
  logic                  stop_ctrl_reg, stop_ctrl_next;
  logic                  host_ready_reg, host_ready_next;
  logic                  armed_reg, armed_next;
  logic                  running_reg, running_next;
  logic                  iter_tick_reg, iter_tick_next;
  logic                  err_reg, err_next;
  logic                  accept;

  assign accept = host_valid && host_ready_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      word_cnt_reg   <= '0;
      cyc_cnt_reg    <= '0;
      ctrl_in_reg    <= '0;
      load_ctrl_reg  <= 1'b0;
      start_ctrl_reg <= 1'b0;
      stop_ctrl_reg  <= 1'b0;
      host_ready_reg <= 1'b0;
      armed_reg      <= 1'b0;
      running_reg    <= 1'b0;
      iter_tick_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      ctrl_in_reg    <= ctrl_in_next;
      load_ctrl_reg  <= load_ctrl_next;
      start_ctrl_reg <= start_ctrl_next;
      stop_ctrl_reg  <= stop_ctrl_next;
      host_ready_reg <= host_ready_next;
      armed_reg      <= armed_next;
      running_reg    <= running_next;
      iter_tick_reg  <= iter_tick_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    ctrl_in_next    = ctrl_in_reg;
    load_ctrl_next  = 1'b0;
    start_ctrl_next = 1'b0;
    stop_ctrl_next  = 1'b0;
    iter_tick_next  = 1'b0;
    err_next        = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (cfg_go) begin
          state_next    = LOAD;
          word_cnt_next = '0;
          err_next      = 1'b0;
        end
      end
      LOAD: begin
        // halt wins over a word offered in the same cycle; that word is dropped
        if (halt_req) begin
          state_next = IDLE;
        end else if (accept) begin
          load_ctrl_next = 1'b1;
          ctrl_in_next   = host_word;
          word_cnt_next  = word_cnt_reg + CNT_W'(1);
          if ((word_cnt_reg == LAST_WORD) && host_last) begin
            state_next = ARM;
          end else if ((word_cnt_reg == LAST_WORD) || host_last) begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
      end
      ARM: begin
        if (halt_req) begin
          state_next = IDLE;
        end else if (run_req) begin
          state_next      = RUN;
          start_ctrl_next = 1'b1;
          cyc_cnt_next    = '0;
        end else if (cfg_go) begin
          state_next    = LOAD;
          word_cnt_next = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_next     = IDLE;
          stop_ctrl_next = 1'b1;
          cyc_cnt_next   = '0;
        end else if (cyc_cnt_reg == LAST_CYC) begin
          cyc_cnt_next   = '0;
          iter_tick_next = 1'b1;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // status flags reflect the state the FSM is about to occupy
    host_ready_next = (state_next == LOAD);
    armed_next      = (state_next == ARM);
    running_next    = (state_next == RUN);
  end

  assign host_ready = host_ready_reg;
  assign load_ctrl  = load_ctrl_reg;
  assign ctrl_in    = ctrl_in_reg;
  assign start_ctrl = start_ctrl_reg;
  assign stop_ctrl  = stop_ctrl_reg;
  assign armed      = armed_reg;
  assign running    = running_reg;
  assign iter_tick  = iter_tick_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_sched_loader.sv
// Bench for sched_loader: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and timings.
`timescale 1ns/1ps
module tb_sched_loader;

  localparam int CW = 24;
  localparam int IP = 48;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_ARM  = 2;
  localparam int P_RUN  = 3;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          cfg_go     = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_last  = 1'b0;
  logic          run_req    = 1'b0;
  logic          halt_req   = 1'b0;
  logic [CW-1:0] host_word  = '0;
  logic          host_ready, load_ctrl, start_ctrl, stop_ctrl;
  logic          armed, running, iter_tick, err;
  logic [CW-1:0] ctrl_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sched_loader #(.CTRL_WIDTH(CW), .ITER_PERIOD(IP)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_go     (cfg_go),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_word  (host_word),
    .host_last  (host_last),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .load_ctrl  (load_ctrl),
    .ctrl_in    (ctrl_in),
    .start_ctrl (start_ctrl),
    .stop_ctrl  (stop_ctrl),
    .armed      (armed),
    .running    (running),
    .iter_tick  (iter_tick),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            phase;
    int            words;
    int            cyc;
    int            start;
    logic          ready, load, start_p, stop_p, armed, running, tick, err;
    logic [CW-1:0] ctrl;
  } model_t;

  model_t m;

  function automatic model_t model_reset(input model_t cur);
    model_t n;
    n.phase = P_IDLE; n.words = 0; n.cyc = cur.cyc; n.start = 0;
    n.ready = 0; n.load = 0; n.start_p = 0; n.stop_p = 0;
    n.armed = 0; n.running = 0; n.tick = 0; n.err = 0; n.ctrl = '0;
    return n;
  endfunction

  function automatic model_t model_step(input model_t cur, input logic go, input logic hv,
                                        input logic [CW-1:0] hw, input logic hl,
                                        input logic rr, input logic hr);
    model_t n = cur;
    n.cyc = cur.cyc + 1;
    n.load = 0; n.start_p = 0; n.stop_p = 0; n.tick = 0;
    case (cur.phase)
      P_IDLE: if (go) begin n.phase = P_LOAD; n.words = 0; n.err = 0; end
      P_LOAD: begin
        if (hr) n.phase = P_IDLE;
        else if (hv) begin
          n.load = 1; n.ctrl = hw; n.words = cur.words + 1;
          if (n.words == IP && hl) n.phase = P_ARM;
          else if (n.words == IP || hl) begin n.phase = P_IDLE; n.err = 1; end
        end
      end
      P_ARM: begin
        if (hr) n.phase = P_IDLE;
        else if (rr) begin n.phase = P_RUN; n.start_p = 1; n.start = n.cyc; end
        else if (go) begin n.phase = P_LOAD; n.words = 0; end
      end
      P_RUN: begin
        if (hr) begin n.phase = P_IDLE; n.stop_p = 1; end
        else n.tick = (((n.cyc - cur.start) % IP) == 0);
      end
      default: n.phase = P_IDLE;
    endcase
    n.ready   = (n.phase == P_LOAD);
    n.armed   = (n.phase == P_ARM);
    n.running = (n.phase == P_RUN);
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset(m);
    else      m <= model_step(m, cfg_go, host_valid, host_word, host_last, run_req, halt_req);
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("host_ready", 32'(host_ready), 32'(m.ready));
    chk("load_ctrl",  32'(load_ctrl),  32'(m.load));
    chk("ctrl_in",    32'(ctrl_in),    32'(m.ctrl));
    chk("start_ctrl", 32'(start_ctrl), 32'(m.start_p));
    chk("stop_ctrl",  32'(stop_ctrl),  32'(m.stop_p));
    chk("armed",      32'(armed),      32'(m.armed));
    chk("running",    32'(running),    32'(m.running));
    chk("iter_tick",  32'(iter_tick),  32'(m.tick));
    chk("err",        32'(err),        32'(m.err));
  end

  // ---------------- event monitor ----------------
  int tb_cyc = 0, n_load = 0, n_start = 0, n_stop = 0, start_cyc = 0;
  int rx_q[$];
  int tick_q[$];

  always @(negedge clk) begin
    tb_cyc <= tb_cyc + 1;
    if (load_ctrl)  begin n_load <= n_load + 1; rx_q.push_back(int'(ctrl_in)); end
    if (start_ctrl) begin n_start <= n_start + 1; start_cyc <= tb_cyc; end
    if (stop_ctrl)  n_stop <= n_stop + 1;
    if (iter_tick)  tick_q.push_back(tb_cyc - start_cyc);
  end

  // ---------------- stimulus ----------------
  int b_load, b_start, b_stop, b_rx, b_tick;

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic send_word(input logic [CW-1:0] w, input logic last);
    int waited = 0;
    host_valid = 1'b1; host_word = w; host_last = last;
    while (host_ready !== 1'b1 && waited < 50) begin step(1); waited++; end
    chk("ready_wait", 32'(host_ready), 32'd1);
    step(1);
    host_valid = 1'b0; host_last = 1'b0;
  endtask

  task automatic snap();
    b_load = n_load; b_start = n_start; b_stop = n_stop;
    b_rx = rx_q.size(); b_tick = tick_q.size();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_load"},  32'(load_ctrl),  32'd0);
    chk({tag, "_ctrl"},  32'(ctrl_in),    32'd0);
    chk({tag, "_start"}, 32'(start_ctrl), 32'd0);
    chk({tag, "_stop"},  32'(stop_ctrl),  32'd0);
    chk({tag, "_armed"}, 32'(armed),      32'd0);
    chk({tag, "_run"},   32'(running),    32'd0);
    chk({tag, "_tick"},  32'(iter_tick),  32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
  endtask

  task automatic chk_order(input string tag, input int first);
    for (int i = 0; i < IP; i++)
      if (rx_q.size() > b_rx + i) chk(tag, 32'(rx_q[b_rx + i]), 32'(first + i));
  endtask

  initial begin
    #1 rst = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b1;
    step(3);
    $display("reset: outputs cleared, released");

    // nominal load of 0x000001..0x000030
    snap();
    cfg_go = 1'b1; step(1); cfg_go = 1'b0;
    for (int i = 1; i <= IP; i++) send_word(CW'(i), i == IP);
    step(2);
    chk("nom_load_count", 32'(n_load - b_load), 32'd48);
    chk("nom_rx_count", 32'(rx_q.size() - b_rx), 32'd48);
    chk_order("nom_order", 1);
    chk("nom_armed", 32'(armed), 32'd1);
    chk("nom_err", 32'(err), 32'd0);
    $display("nominal load: %0d words forwarded, armed=%0b", n_load - b_load, armed);

    // run for three iterations, then halt
    snap();
    run_req = 1'b1; step(1); run_req = 1'b0;
    chk("run_start_pulse", 32'(start_ctrl), 32'd1);
    chk("run_running", 32'(running), 32'd1);
    step(150);
    chk("tick_count", 32'(tick_q.size() - b_tick), 32'd3);
    for (int k = 0; k < 3; k++)
      if (tick_q.size() > b_tick + k) chk("tick_offset", 32'(tick_q[b_tick + k]), 32'(48 * (k + 1)));
    halt_req = 1'b1; step(1); halt_req = 1'b0;
    chk("halt_stop_pulse", 32'(stop_ctrl), 32'd1);
    chk("halt_running", 32'(running), 32'd0);
    step(2);
    chk("run_start_count", 32'(n_start - b_start), 32'd1);
    chk("run_stop_count", 32'(n_stop - b_stop), 32'd1);
    $display("run: %0d iteration ticks, stop issued", tick_q.size() - b_tick);

    // framing error: host_last on word 10
    snap();
    cfg_go = 1'b1; step(1); cfg_go = 1'b0;
    for (int i = 1; i <= 10; i++) send_word(CW'(32'h100 + i), i == 10);
    step(2);
    chk("early_load_count", 32'(n_load - b_load), 32'd10);
    chk("early_err", 32'(err), 32'd1);
    chk("early_armed", 32'(armed), 32'd0);
    chk("early_ready", 32'(host_ready), 32'd0);
    run_req = 1'b1; step(1); run_req = 1'b0;
    step(2);
    chk("early_no_start", 32'(n_start - b_start), 32'd0);
    $display("early host_last: %0d words forwarded, err=%0b", n_load - b_load, err);

    // framing error: no host_last on word 48
    snap();
    cfg_go = 1'b1; step(1); cfg_go = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    for (int i = 1; i <= IP; i++) send_word(CW'(32'h200 + i), 1'b0);
    step(2);
    chk("late_load_count", 32'(n_load - b_load), 32'd48);
    chk("late_err", 32'(err), 32'd1);
    chk("late_armed", 32'(armed), 32'd0);
    $display("missing host_last: %0d words forwarded, err=%0b", n_load - b_load, err);

    // backpressure: valid every other cycle
    snap();
    cfg_go = 1'b1; step(1); cfg_go = 1'b0;
    for (int i = 1; i <= IP; i++) begin
      step(1);
      send_word(CW'(32'h400 + i), i == IP);
    end
    step(2);
    chk("bp_load_count", 32'(n_load - b_load), 32'd48);
    chk("bp_rx_count", 32'(rx_q.size() - b_rx), 32'd48);
    chk_order("bp_order", 32'h401);
    chk("bp_armed", 32'(armed), 32'd1);
    chk("bp_err", 32'(err), 32'd0);
    $display("backpressure load: %0d words forwarded", n_load - b_load);

    // halt_req together with run_req in ARM
    snap();
    halt_req = 1'b1; run_req = 1'b1; step(1); halt_req = 1'b0; run_req = 1'b0;
    step(2);
    chk("hr_no_start", 32'(n_start - b_start), 32'd0);
    chk("hr_no_stop", 32'(n_stop - b_stop), 32'd0);
    chk("hr_armed", 32'(armed), 32'd0);
    chk("hr_running", 32'(running), 32'd0);
    $display("halt+run in ARM: returned to idle");

    // asynchronous reset during a load, after word 20
    cfg_go = 1'b1; step(1); cfg_go = 1'b0;
    for (int i = 1; i <= 20; i++) send_word(CW'(32'h300 + i), 1'b0);
    host_valid = 1'b1; host_word = CW'(32'h315);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    host_valid = 1'b0;
    step(3);
    rst = 1'b1;
    snap();
    step(10);
    chk("post_rst_load", 32'(n_load - b_load), 32'd0);
    chk("post_rst_start", 32'(n_start - b_start), 32'd0);
    chk("post_rst_stop", 32'(n_stop - b_stop), 32'd0);
    chk("post_rst_ready", 32'(host_ready), 32'd0);
    $display("async reset mid-load: outputs cleared, idle after release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sched_loader.md
SCHED_LOADER -- requirements
Module: sched_loader

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 24, meaning control word width (two toggle bits per buffer, 12 buffers).
REQ-002 SHALL have parameter ITER_PERIOD, default 48, meaning control words per schedule and cycles per iteration.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_go, input, 1, meaning the request to begin loading a schedule.
REQ-006 SHALL have port host_valid, input, 1, meaning host_word is valid.
REQ-007 SHALL have port host_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port host_word, input, CTRL_WIDTH, meaning one schedule word from the host.
REQ-009 SHALL have port host_last, input, 1, meaning the host marks its final word.
REQ-010 SHALL have port run_req, input, 1, meaning the request to start the loaded schedule.
REQ-011 SHALL have port halt_req, input, 1, meaning the request to abort a load or stop a run.
REQ-012 SHALL have port load_ctrl, output, 1, meaning ctrl_in is to be written to the schedule controller.
REQ-013 SHALL have port ctrl_in, output, CTRL_WIDTH, meaning the schedule word being written.
REQ-014 SHALL have ports start_ctrl and stop_ctrl, output, 1 each, meaning one-cycle start and stop pulses to the schedule controller.
REQ-015 SHALL have port armed, output, 1, meaning a full schedule is loaded and run has not started.
REQ-016 SHALL have port running, output, 1, meaning the schedule is executing.
REQ-017 SHALL have port iter_tick, output, 1, meaning a one-cycle pulse at each iteration boundary.
REQ-018 SHALL have port err, output, 1, meaning sticky framing error.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, ARM and RUN, with all outputs registered.
REQ-020 IDLE: cfg_go=1 SHALL enter LOAD, clear word_cnt to 0 and clear err; run_req and halt_req are ignored.
REQ-021 LOAD: host_ready SHALL be 1; a word is accepted when host_valid and host_ready are both 1.
REQ-022 Each accepted word SHALL appear on ctrl_in with load_ctrl=1 exactly 1 cycle later; load_ctrl=0 in every other cycle, and ctrl_in holds its last value.
REQ-023 word_cnt SHALL have width $clog2(ITER_PERIOD+1) and increment once per accepted word.
REQ-024 An accepted word with word_cnt==ITER_PERIOD-1 and host_last=1 SHALL move the FSM to ARM.
REQ-025 A host_last/count mismatch (host_last=1 early, or host_last=0 on word ITER_PERIOD) SHALL set err=1 and return the FSM to IDLE; that word is still forwarded on load_ctrl, and start_ctrl is never issued.
REQ-026 halt_req=1 in LOAD SHALL return the FSM to IDLE without setting err; a word accepted in the same cycle is not forwarded.
REQ-027 ARM: armed SHALL be 1 and host_ready 0; run_req=1 SHALL pulse start_ctrl for 1 cycle (the cycle after run_req) and enter RUN; halt_req SHALL enter IDLE without a pulse; cfg_go SHALL restart LOAD with word_cnt=0.
REQ-028 RUN: running SHALL be 1; cycle counter cyc_cnt SHALL count 0..ITER_PERIOD-1 from the start_ctrl cycle, and iter_tick SHALL pulse when it wraps from ITER_PERIOD-1 to 0.
REQ-029 RUN: halt_req=1 SHALL pulse stop_ctrl for 1 cycle the next cycle and enter IDLE; cfg_go and run_req are ignored.
REQ-030 When halt_req and cfg_go or run_req are asserted in the same cycle, halt_req SHALL take priority.
REQ-031 start_ctrl and stop_ctrl SHALL never be high in the same cycle, and load_ctrl SHALL never be high in RUN.

Reset
REQ-032 rst=0 SHALL force IDLE immediately and set word_cnt, cyc_cnt, ctrl_in, load_ctrl, start_ctrl, stop_ctrl, host_ready, armed, running, iter_tick and err to 0.
REQ-033 Reset mid-LOAD or mid-RUN SHALL emit no further load_ctrl, start_ctrl or stop_ctrl pulses; after release the FSM waits in IDLE.

Verification
REQ-034 SHALL cover a nominal load: cfg_go, then 48 words 0x000001..0x000030 with host_last on the 48th -> 48 load_ctrl pulses, each ctrl_in equal to its word one cycle late, then armed=1 and err=0.
REQ-035 SHALL cover backpressure: host_valid toggled every other cycle during a load -> exactly 48 load_ctrl pulses, in order, with no duplicates.
REQ-036 SHALL cover framing errors: host_last on word 10 -> err=1, IDLE, 10 load_ctrl pulses, no start_ctrl; missing host_last on word 48 -> err=1, no ARM.
REQ-037 SHALL cover a run: run_req in ARM -> start_ctrl one cycle later; iter_tick at cycles 48, 96 and 144 after start; halt_req -> stop_ctrl next cycle, running=0.
REQ-038 SHALL cover the simultaneous halt_req+run_req case in ARM -> IDLE with no start_ctrl.
REQ-039 SHALL cover async reset asserted mid-LOAD at word 20 -> all outputs 0 within the same cycle; after release the FSM stays in IDLE with no pulses.
